// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared types for the RAM-backed FIFO controller: RAM port grant encoding
// and the fair push/pop arbitration function.
package ram_fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_READ,
        GRANT_WRITE
    } grant_e;

    // last_grant is 1 when the previous contention went to the write side.
    function automatic grant_e arbitrate(input logic rd_want,
                                         input logic wr_want,
                                         input logic last_grant);
        if (rd_want && wr_want) return last_grant ? GRANT_READ : GRANT_WRITE;
        if (wr_want)            return GRANT_WRITE;
        if (rd_want)            return GRANT_READ;
        return GRANT_NONE;
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Valid/ready word stream used for both the producer and consumer sides.
interface ram_fifo_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic                 valid;
    logic                 ready;
    logic [DATA_BITS-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ram_fifo_obuf.sv
// Two-entry output buffer that absorbs RAM read data; head entry drives the
// consumer, same-cycle pop removes the head before the new word is appended.
module ram_fifo_obuf #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] head,
    output logic [1:0]           count
);

    logic [DATA_BITS-1:0] head_q, tail_q, head_d, tail_d;
    logic [1:0]           count_q, fill_idx;

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        head_d   = pop ? tail_q : head_q;
        tail_d   = tail_q;
        fill_idx = count_q - 2'(pop);
        if (push) begin
            if (fill_idx == 2'd0) head_d = push_data;
            else                  tail_d = push_data;
        end
    end

    // NOTE: these are two plain registers, not a RAM, so they take the reset and out_data reads 0 afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    assign head  = head_q;
    assign count = count_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around a single-port synchronous RAM with one-cycle read
// latency; push and pop share the RAM port through a fair arbiter.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int ADDRESS_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ram_fifo_ctrl_if.slave          in_bus,
    ram_fifo_ctrl_if.master         out_bus,
    output logic                    ram_write,
    output logic [ADDRESS_BITS-1:0] ram_addr,
    output logic [DATA_BITS-1:0]    ram_wdata,
    input  logic [DATA_BITS-1:0]    ram_rdata,
    output logic [ADDRESS_BITS+1:0] level
);

    localparam int DEPTH = 2 ** ADDRESS_BITS;
    localparam int CNT_W = ADDRESS_BITS + 1;
    localparam int LVL_W = ADDRESS_BITS + 2;

    logic [ADDRESS_BITS-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        ram_cnt;
    logic                    rd_pend;
    logic                    last_grant;
    logic [1:0]              out_cnt;
    logic [DATA_BITS-1:0]    out_head;

    logic       pop, rd_want, wr_want, grant_rd, grant_wr;
    logic [2:0] obuf_claim;
    grant_e     grant;

    // Words the output buffer will hold once the pending read lands; a new
    // read is only issued if that leaves room for it.
    always_comb begin
        pop        = (out_cnt != 2'd0) && out_bus.ready;
        obuf_claim = {1'b0, out_cnt} + 3'(rd_pend) - 3'(pop);
        rd_want    = (ram_cnt != '0) && (obuf_claim <= 3'd1);
        wr_want    = rst_n && in_bus.valid && (ram_cnt != CNT_W'(DEPTH));
        grant      = arbitrate(rd_want, wr_want, last_grant);
        grant_rd   = (grant == GRANT_READ);
        grant_wr   = (grant == GRANT_WRITE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            rd_pend    <= 1'b0;
            last_grant <= 1'b0;
        end else begin
            if (grant_wr) begin
                wr_ptr  <= wr_ptr + ADDRESS_BITS'(1);
                ram_cnt <= ram_cnt + CNT_W'(1);
            end else if (grant_rd) begin
                rd_ptr  <= rd_ptr + ADDRESS_BITS'(1);
                ram_cnt <= ram_cnt - CNT_W'(1);
            end
            rd_pend <= grant_rd;
            if (rd_want && wr_want) last_grant <= grant_wr;
        end
    end

    ram_fifo_obuf #(
        .DATA_BITS (DATA_BITS)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend),
        .push_data (ram_rdata),
        .pop       (pop),
        .head      (out_head),
        .count     (out_cnt)
    );

    assign in_bus.ready  = grant_wr;
    assign ram_write     = grant_wr;
    assign ram_addr      = grant_wr ? wr_ptr : rd_ptr;
    assign ram_wdata     = in_bus.data;
    assign out_bus.valid = (out_cnt != 2'd0);
    assign out_bus.data  = out_head;
    assign level         = LVL_W'(ram_cnt) + LVL_W'(rd_pend) + LVL_W'(out_cnt);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: behavioural single-port RAM, a
// cycle-exact vector table, and a scoreboard for the streaming sequences.
module tb_ram_fifo_ctrl;

    localparam int DATA_BITS    = 8;
    localparam int ADDRESS_BITS = 4;
    localparam int DEPTH        = 2 ** ADDRESS_BITS;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    ram_write;
    logic [ADDRESS_BITS-1:0] ram_addr;
    logic [DATA_BITS-1:0]    ram_wdata;
    logic [DATA_BITS-1:0]    ram_rdata = '0;
    logic [ADDRESS_BITS+1:0] level;

    ram_fifo_ctrl_if #(.DATA_BITS(DATA_BITS)) in_bus ();
    ram_fifo_ctrl_if #(.DATA_BITS(DATA_BITS)) out_bus ();

    ram_fifo_ctrl #(
        .DATA_BITS    (DATA_BITS),
        .ADDRESS_BITS (ADDRESS_BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bus    (in_bus),
        .out_bus   (out_bus),
        .ram_write (ram_write),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .level     (level)
    );

    always #5 clk = ~clk;

    logic [DATA_BITS-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    logic [DATA_BITS-1:0] sb_q[$];
    bit                   sb_on    = 1'b0;
    int                   push_cnt = 0;
    int                   pop_cnt  = 0;

    always @(negedge clk) begin
        if (sb_on && rst_n) begin
            if (in_bus.valid && in_bus.ready) begin
                sb_q.push_back(in_bus.data);
                push_cnt++;
            end
            if (out_bus.valid && out_bus.ready) begin
                pop_cnt++;
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: got 0x%0h, expected no word at %0t", out_bus.data, $time);
                end else begin
                    check("sb_data", 32'(out_bus.data), 32'(sb_q.pop_front()));
                end
            end
        end
    end

    typedef struct {
        logic                    iv;
        logic [DATA_BITS-1:0]    id;
        logic                    ordy;
        logic                    e_irdy;
        logic                    e_wr;
        logic [ADDRESS_BITS-1:0] e_addr;
        logic                    e_ov;
        logic [DATA_BITS-1:0]    e_od;
        logic [ADDRESS_BITS+1:0] e_lvl;
    } vec_t;

    vec_t vecs [13];

    task automatic push_word(input logic [DATA_BITS-1:0] d, input bit rand_rdy);
        bit done = 1'b0;
        in_bus.valid = 1'b1;
        in_bus.data  = d;
        for (int i = 0; i < 64 && !done; i++) begin
            if (rand_rdy) out_bus.ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            done = in_bus.ready;
            @(posedge clk);
            #1;
        end
        in_bus.valid = 1'b0;
        check("push_accepted", 32'(done), 32'd1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        in_bus.valid  = 1'b0;
        out_bus.ready = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = (sb_q.size() == 0) && (level == '0);
            @(posedge clk);
            #1;
        end
        check("drain_done", 32'(done), 32'd1);
    endtask

    task automatic pulse_reset();
        sb_on = 1'b0;
        @(posedge clk);
        #2;
        rst_n         = 1'b0;
        in_bus.valid  = 1'b0;
        out_bus.ready = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb_on = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        bit  got;
        logic [DATA_BITS-1:0] d;

        // Reset held with a producer already offering data.
        in_bus.valid  = 1'b1;
        in_bus.data   = 8'hFF;
        out_bus.ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready",  32'(in_bus.ready),  32'd0);
            check("rst_ram_write", 32'(ram_write),     32'd0);
            check("rst_out_valid", 32'(out_bus.valid), 32'd0);
            check("rst_level",     32'(level),         32'd0);
        end
        check("rst_out_data", 32'(out_bus.data), 32'd0);
        @(posedge clk);
        #2;
        rst_n        = 1'b1;
        in_bus.valid = 1'b0;
        @(posedge clk);
        #1;

        //            iv    id     ordy  irdy  wr    addr   ov    od     lvl
        vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 8'h00, 6'd0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 6'd1};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 8'h00, 6'd1};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 8'hA5, 6'd1};
        vecs[4]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 8'h00, 6'd0};
        vecs[5]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 8'h00, 6'd1};
        vecs[6]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 8'h00, 6'd2};
        vecs[7]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 8'h00, 6'd2};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 8'h11, 6'd3};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 8'h00, 6'd2};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 8'h22, 6'd2};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 8'h33, 6'd1};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 8'h00, 6'd0};

        foreach (vecs[i]) begin
            in_bus.valid  = vecs[i].iv;
            in_bus.data   = vecs[i].id;
            out_bus.ready = vecs[i].ordy;
            @(negedge clk);
            check($sformatf("vec%0d_in_ready", i),  32'(in_bus.ready),  32'(vecs[i].e_irdy));
            check($sformatf("vec%0d_ram_write", i), 32'(ram_write),     32'(vecs[i].e_wr));
            check($sformatf("vec%0d_ram_addr", i),  32'(ram_addr),      32'(vecs[i].e_addr));
            check($sformatf("vec%0d_out_valid", i), 32'(out_bus.valid), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d_level", i),     32'(level),         32'(vecs[i].e_lvl));
            if (vecs[i].e_ov)
                check($sformatf("vec%0d_out_data", i), 32'(out_bus.data), 32'(vecs[i].e_od));
            @(posedge clk);
            #1;
        end
        in_bus.valid  = 1'b0;
        out_bus.ready = 1'b0;
        sb_on         = 1'b1;

        // Fill to 16 in RAM plus 2 in the output buffer, then drain in order.
        base = pop_cnt;
        for (int i = 0; i < 18; i++) push_word(8'(i), 1'b0);
        in_bus.valid = 1'b1;
        in_bus.data  = 8'h12;
        repeat (3) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_bus.ready), 32'd0);
            check("full_level",    32'(level),        32'd18);
            @(posedge clk);
            #1;
        end
        out_bus.ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = in_bus.ready;
            @(posedge clk);
            #1;
        end
        check("refill_in_ready", 32'(got), 32'd1);
        drain();
        check("full_pop_count", 32'(pop_cnt - base), 32'd19);

        // Simultaneous push and pop demand from empty: port alternates.
        pulse_reset();
        d = 8'h80;
        out_bus.ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            in_bus.valid = 1'b1;
            in_bus.data  = d;
            @(negedge clk);
            check($sformatf("alt%0d_ram_write", k), 32'(ram_write), 32'((k == 0) || (k % 2 == 1)));
            check("alt_level_bound", 32'(level <= 6'd18), 32'd1);
            got = in_bus.ready;
            @(posedge clk);
            #1;
            if (got) d = d + 8'd1;
        end
        drain();

        // Prefill 10 words, then drain: one word per cycle for 10 cycles.
        pulse_reset();
        for (int i = 0; i < 10; i++) push_word(8'(8'h40 + i), 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        out_bus.ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("burst%0d_out_valid", k), 32'(out_bus.valid), 32'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("burst_end_out_valid", 32'(out_bus.valid), 32'd0);
        @(posedge clk);
        #1;
        drain();

        // 40 words with a random consumer: both pointers wrap twice.
        pulse_reset();
        base = pop_cnt;
        for (int i = 0; i < 40; i++) push_word(8'(i * 7 + 3), 1'b1);
        drain();
        check("wrap_pop_count", 32'(pop_cnt - base), 32'd40);

        // Asynchronous reset mid-stream discards everything held.
        out_bus.ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(8'(8'hC0 + i), 1'b0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = out_bus.valid;
        end
        check("midrst_pre_out_valid", 32'(got), 32'd1);
        @(posedge clk);
        #2;
        sb_on = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_bus.valid), 32'd0);
        check("midrst_level",     32'(level),         32'd0);
        check("midrst_in_ready",  32'(in_bus.ready),  32'd0);
        sb_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb_on = 1'b1;
        base  = pop_cnt;
        out_bus.ready = 1'b1;
        push_word(8'h5A, 1'b0);
        push_word(8'h5B, 1'b0);
        drain();
        check("midrst_pop_count", 32'(pop_cnt - base), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
